unary_add_13_driver: RTL and testbench

Initiator and collector for the mod-13 unary adder digit. It accepts two binary digits plus a carry-in over a valid/ready handshake. It serialises them into unary pulse streams on the adder's A/B inputs in the read phase, then switches the adder to the write phase and counts the dout pulse train back into a binary sum. It also captures the adder's carry and returns {sum, cout} over a second valid/ready handshake. It sits between binary datapath logic and one unary adder digit, and is the building block for multi-digit chains (cout feeds the next digit's cin).

---
 rtl/unary_add_13_driver_if.sv | 32 +++
 rtl/unary_add_13_driver.sv | 103 ++++++++++
 tb/tb_unary_add_13_driver.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/unary_add_13_driver_if.sv
// Operand/result handshakes plus the unary adder pin bundle for one mod-13 digit driver.
// The slave modport is the driver; the master modport is its environment (datapath + adder).
interface unary_add_13_driver_if #(
   parameter int W = 4
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         err;
   logic         add_A;
   logic         add_B;
   logic         add_en;
   logic         add_rw;
   logic         add_dout;
   logic         add_C;

   modport slave (
      input  in_valid, op_a, op_b, cin, out_ready, add_dout, add_C,
      output in_ready, out_valid, sum, cout, err, add_A, add_B, add_en, add_rw
   );

   modport master (
      output in_valid, op_a, op_b, cin, out_ready, add_dout, add_C,
      input  in_ready, out_valid, sum, cout, err, add_A, add_B, add_en, add_rw
   );
endinterface

// File: rtl/unary_add_13_driver.sv
// Serialises two binary digits into unary pulses for a mod-MOD adder and counts the drained sum back.
// Latency 2+max(a+cin,b)+MOD+1 edges from accept; result held in DONE until out_ready, one op in flight.
module unary_add_13_driver #(
   parameter int MOD = 13,
   parameter int W   = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   unary_add_13_driver_if.slave bus
);
   localparam int DW = $clog2(MOD + 2);

   typedef enum logic [2:0] {IDLE, SEND, SETTLE, DRAIN, DONE} state_t;

   state_t        state;
   logic [W-1:0]  ca;
   logic [W-1:0]  cb;
   logic [W-1:0]  sum_cnt;
   logic [DW-1:0] drain_cnt;
   logic          carry_acc;
   logic          err_q;
   logic          rdy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ca        <= '0;
         cb        <= '0;
         sum_cnt   <= '0;
         drain_cnt <= '0;
         carry_acc <= 1'b0;
         err_q     <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && rdy_q) begin
                  ca        <= bus.op_a + W'(bus.cin);
                  cb        <= bus.op_b;
                  sum_cnt   <= '0;
                  carry_acc <= 1'b0;
                  drain_cnt <= '0;
                  rdy_q     <= 1'b0;
                  if (bus.op_a >= W'(MOD) || bus.op_b >= W'(MOD)) begin
                     err_q <= 1'b1;
                     state <= DONE;
                  end else begin
                     err_q <= 1'b0;
                     if (bus.op_a == '0 && bus.op_b == '0 && !bus.cin)
                        state <= SETTLE;
                     else
                        state <= SEND;
                  end
               end else begin
                  rdy_q <= 1'b1;
               end
            end
            SEND: begin
               carry_acc <= carry_acc | bus.add_C;
               if (ca != '0) ca <= ca - W'(1);
               if (cb != '0) cb <= cb - W'(1);
               if (ca <= W'(1) && cb <= W'(1)) state <= SETTLE;
            end
            SETTLE: begin
               // C from the last SEND pulse only becomes visible here
               carry_acc <= carry_acc | bus.add_C;
               drain_cnt <= '0;
               state     <= DRAIN;
            end
            DRAIN: begin
               if (bus.add_dout) begin
                  if (sum_cnt == W'(MOD - 1))
                     err_q <= 1'b1;
                  else
                     sum_cnt <= sum_cnt + W'(1);
               end
               if (drain_cnt == DW'(MOD))
                  state <= DONE;
               else
                  drain_cnt <= drain_cnt + DW'(1);
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
                  rdy_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Adder pins are pure decodes of flops so nothing combinational reaches the adder.
   assign bus.in_ready  = rdy_q;
   assign bus.out_valid = (state == DONE);
   assign bus.sum       = sum_cnt;
   assign bus.cout      = carry_acc;
   assign bus.err       = err_q;
   assign bus.add_en    = (state == SEND) || (state == DRAIN);
   assign bus.add_rw    = (state == DRAIN);
   assign bus.add_A     = (state == SEND) && (ca != '0);
   assign bus.add_B     = (state == SEND) && (cb != '0);
endmodule

// File: tb/tb_unary_add_13_driver.sv
// Directed plus random operations against an arithmetic reference, with a behavioural mod-13 adder on the pins.
module tb_unary_add_13_driver;
   localparam int MOD = 13;
   localparam int W   = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   unary_add_13_driver_if #(.W(W)) bus ();

   unary_add_13_driver #(.MOD(MOD), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Unary adder digit: accumulates A+B in read phase, drains one dout pulse per count in write phase.
   int acc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc          <= 0;
         bus.add_C    <= 1'b0;
         bus.add_dout <= 1'b0;
      end else if (bus.add_en) begin
         if (!bus.add_rw) begin
            bus.add_dout <= 1'b0;
            if (acc + int'(bus.add_A) + int'(bus.add_B) >= MOD) begin
               acc       <= acc + int'(bus.add_A) + int'(bus.add_B) - MOD;
               bus.add_C <= 1'b1;
            end else begin
               acc <= acc + int'(bus.add_A) + int'(bus.add_B);
            end
         end else begin
            bus.add_C <= 1'b0;
            if (acc > 0) begin
               bus.add_dout <= 1'b1;
               acc          <= acc - 1;
            end else begin
               bus.add_dout <= 1'b0;
            end
         end
      end else begin
         bus.add_dout <= 1'b0;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int edges, send_cyc, a_cnt, b_cnt, dout_cnt;
   bit en_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start_op(input int a, input int b, input int c);
      int n = 0;
      while (bus.in_ready !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) chk("in_ready_timeout", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.op_a     = W'(a);
      bus.op_b     = W'(b);
      bus.cin      = c[0];
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.op_a     = W'($urandom);
      bus.op_b     = W'($urandom);
      bus.cin      = 1'($urandom);
      edges    = 1;
      send_cyc = 0;
      a_cnt    = 0;
      b_cnt    = 0;
      dout_cnt = 0;
      en_seen  = 1'b0;
   endtask

   task automatic collect();
      while (bus.out_valid !== 1'b1 && edges < 100) begin
         if (bus.add_en) en_seen = 1'b1;
         if (bus.add_en && !bus.add_rw) begin
            send_cyc++;
            a_cnt += int'(bus.add_A);
            b_cnt += int'(bus.add_B);
         end
         if (bus.add_en && bus.add_rw && bus.add_dout) dout_cnt++;
         @(negedge clk);
         edges++;
      end
      if (edges >= 100) chk("out_valid_timeout", 32'(bus.out_valid), 1);
   endtask

   task automatic check_result(input int a, input int b, input int c);
      int total  = a + b + c;
      bit bad    = (a >= MOD) || (b >= MOD);
      int e_sum  = bad ? 0 : total % MOD;
      int e_cout = (!bad && total >= MOD) ? 1 : 0;
      int e_send = (a + c > b) ? a + c : b;
      chk("sum",  32'(bus.sum),  32'(e_sum));
      chk("cout", 32'(bus.cout), 32'(e_cout));
      chk("err",  32'(bus.err),  32'(bad));
      if (!bad) begin
         chk("latency",    32'(edges),    32'(2 + e_send + MOD + 1));
         chk("send_cycles", 32'(send_cyc), 32'(e_send));
         chk("a_pulses",   32'(a_cnt),    32'(a + c));
         chk("b_pulses",   32'(b_cnt),    32'(b));
         chk("dout_pulses", 32'(dout_cnt), 32'(e_sum));
      end else begin
         chk("err_no_add_en", 32'(en_seen), 0);
      end
   endtask

   task automatic finish_op(input int hold);
      logic [W-1:0] s  = bus.sum;
      logic         co = bus.cout;
      logic         er = bus.err;
      repeat (hold) begin
         @(negedge clk);
         chk("hold_sum",      32'(bus.sum),       32'(s));
         chk("hold_cout",     32'(bus.cout),      32'(co));
         chk("hold_err",      32'(bus.err),       32'(er));
         chk("hold_valid",    32'(bus.out_valid), 1);
         chk("hold_in_ready", 32'(bus.in_ready),  0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("post_in_ready",  32'(bus.in_ready),  1);
      chk("post_out_valid", 32'(bus.out_valid), 0);
   endtask

   task automatic run_op(input int a, input int b, input int c, input int hold);
      start_op(a, b, c);
      collect();
      check_result(a, b, c);
      finish_op(hold);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_in_ready"},  32'(bus.in_ready),  0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      chk({tag, "_sum"},       32'(bus.sum),       0);
      chk({tag, "_cout"},      32'(bus.cout),      0);
      chk({tag, "_err"},       32'(bus.err),       0);
      chk({tag, "_add_pins"},
          32'({bus.add_A, bus.add_B, bus.add_en, bus.add_rw}), 0);
   endtask

   initial begin
      int n;
      int a, b, c;
      bus.in_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b0;

      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 32'(bus.in_ready), 1);

      run_op(5, 7, 0, 0);
      run_op(6, 7, 0, 0);
      run_op(12, 12, 1, 0);
      run_op(0, 0, 0, 0);
      run_op(0, 0, 1, 0);
      run_op(13, 4, 0, 0);
      run_op(4, 14, 1, 1);
      run_op(8, 9, 1, 5);
      run_op(3, 4, 0, 0);

      // Abort mid-DRAIN, then confirm nothing leaks into the next operation.
      start_op(9, 3, 1);
      n = 0;
      while (bus.add_rw !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) chk("drain_timeout", 32'(bus.add_rw), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1, 1, 0, 0);

      for (int i = 0; i < 25; i++) begin
         if ($urandom_range(0, 7) == 0) a = int'($urandom_range(0, 15));
         else                           a = int'($urandom_range(0, 12));
         b = int'($urandom_range(0, 12));
         c = int'($urandom_range(0, 1));
         run_op(a, b, c, int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
